// File: rtl/e_mdu_pkg.sv
// Shared MD op codes and state encoding for the E-stage multiply/divide unit.
// The instruction decoder imports this package too, so both sides agree on md_op.
package e_mdu_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MFHI  = 4'd5,
        MD_MFLO  = 4'd6,
        MD_MTHI  = 4'd7,
        MD_MTLO  = 4'd8
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;

    function automatic logic is_multi_cycle(input md_op_e op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_div(input md_op_e op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/e_mdu_md_core.sv
// Combinational MD arithmetic: 64-bit product, or {remainder, quotient} for divides.
// Divide-by-zero is flagged so the caller can leave HI/LO untouched.
module e_mdu_md_core
    import e_mdu_pkg::*;
(
    input  md_op_e       op,
    input  logic [31:0]  a,
    input  logic [31:0]  b,
    output logic [63:0]  result,
    output logic         div_zero
);

    logic signed [63:0] a_sx;
    logic signed [63:0] b_sx;
    logic        [63:0] a_zx;
    logic        [63:0] b_zx;
    logic               div_ovf;
    logic        [31:0] b_u_safe;
    logic signed [31:0] a_s;
    logic signed [31:0] b_s_safe;

    assign a_sx = {{32{a[31]}}, a};
    assign b_sx = {{32{b[31]}}, b};
    assign a_zx = {32'd0, a};
    assign b_zx = {32'd0, b};

    // 0x80000000 / -1 divides by 1 instead: quotient 0x80000000, remainder 0, no overflow.
    assign div_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    assign b_u_safe = (b == 32'd0) ? 32'd1 : b;
    assign a_s      = $signed(a);
    assign b_s_safe = (b == 32'd0 || div_ovf) ? 32'sd1 : $signed(b);

    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        result   = '0;
        div_zero = 1'b0;
        case (op)
            MD_MULT:  result = a_sx * b_sx;
            MD_MULTU: result = a_zx * b_zx;
            MD_DIV: begin
                div_zero = (b == 32'd0);
                result   = {a_s % b_s_safe, a_s / b_s_safe};
            end
            MD_DIVU: begin
                div_zero = (b == 32'd0);
                result   = {a % b_u_safe, a / b_u_safe};
            end
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: owns HI/LO, runs fixed-latency mult/div, and drives e_hl.
// The result is computed at the start edge and held in pending regs until the commit edge.
module e_mdu
    import e_mdu_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  md_op_e       md_op,
    input  logic [31:0]  src_a,
    input  logic [31:0]  src_b,
    output logic         busy,
    output logic [31:0]  hi,
    output logic [31:0]  lo,
    output logic [31:0]  e_hl
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    md_state_e          state, state_nxt;
    logic [CNT_W-1:0]   count;
    logic [31:0]        pend_hi;
    logic [31:0]        pend_lo;
    logic               pend_wr;
    logic [63:0]        core_res;
    logic               core_div_zero;
    logic               accept;
    logic               commit;
    logic               idle_start;

    e_mdu_md_core u_md_core (
        .op       (md_op),
        .a        (src_a),
        .b        (src_b),
        .result   (core_res),
        .div_zero (core_div_zero)
    );

    assign busy       = (state == ST_RUN);
    assign idle_start = start && !busy;
    assign accept     = idle_start && is_multi_cycle(md_op);
    assign commit     = (state == ST_RUN) && (count == CNT_W'(1));

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = ST_RUN;
            ST_RUN:  if (commit) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Reset discards any in-flight result along with the control state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            count   <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            pend_wr <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
            state <= state_nxt;
            if (accept) begin
                count   <= is_div(md_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                pend_hi <= core_res[63:32];
                pend_lo <= core_res[31:0];
                pend_wr <= !core_div_zero;
            end else if (state == ST_RUN) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi <= '0;
            lo <= '0;
        end else if (commit) begin
            if (pend_wr) begin
                hi <= pend_hi;
                lo <= pend_lo;
            end
        end else if (idle_start && md_op == MD_MTHI) begin
            hi <= src_a;
        end else if (idle_start && md_op == MD_MTLO) begin
            lo <= src_a;
        end
    end

    always_comb begin
        e_hl = '0;
        if (md_op == MD_MFHI)      e_hl = hi;
        else if (md_op == MD_MFLO) e_hl = lo;
    end

endmodule

// File: tb/tb_e_mdu.sv
// Scoreboard bench for e_mdu: stimulus pushes expected HI/LO and busy length per multi-cycle op;
// a monitor pops and compares whenever busy falls.
module tb_e_mdu;
    import e_mdu_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    md_op_e       md_op;
    logic [31:0]  src_a;
    logic [31:0]  src_b;
    logic         busy;
    logic [31:0]  hi;
    logic [31:0]  lo;
    logic [31:0]  e_hl;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   ignored_starts = 0;

    e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .md_op (md_op),
        .src_a (src_a),
        .src_b (src_b),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo),
        .e_hl  (e_hl)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push(input string name, input logic [31:0] h, input logic [31:0] l, input int cyc);
        exp_t e;
        e.name = name; e.hi = h; e.lo = l; e.cycles = cyc;
        sb_q.push_back(e);
    endtask

    task automatic issue(input md_op_e op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1; md_op = op; src_a = a; src_b = b;
        @(negedge clk);
        start = 1'b0; md_op = MD_NONE;
    endtask

    task automatic drain(input string name);
        int guard;
        guard = 0;
        while (sb_q.size() != 0 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_timeout: %0d results still pending after %0d cycles", name, sb_q.size(), guard);
            sb_q.delete();
        end
    endtask

    // Monitor: counts busy cycles; when busy falls the committed HI/LO are already visible.
    initial begin
        int   cnt;
        logic prev_busy;
        exp_t e;
        cnt = 0; prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                cnt = 0; prev_busy = 1'b0;
            end else begin
                if (busy) begin
                    cnt++;
                end else if (prev_busy) begin
                    if (sb_q.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL unexpected_commit: hi=0x%08h lo=0x%08h with empty scoreboard", hi, lo);
                    end else begin
                        e = sb_q.pop_front();
                        check({e.name, "_busy_cycles"}, 32'(cnt), 32'(e.cycles));
                        check({e.name, "_hi"}, hi, e.hi);
                        check({e.name, "_lo"}, lo, e.lo);
                    end
                    cnt = 0;
                end
                prev_busy = busy;
            end
        end
    end

    initial begin
        int guard;
        rst = 1'b1; start = 1'b0; md_op = MD_NONE; src_a = '0; src_b = '0;
        #12;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        @(posedge clk); #2 rst = 1'b0;

        // MTHI / MTLO / MFHI / MFLO single-cycle path
        issue(MD_MTHI, 32'h1234_5678, 32'hDEAD_BEEF);
        md_op = MD_MFHI; #1;
        check("mthi_hi", hi, 32'h1234_5678);
        check("mfhi_e_hl", e_hl, 32'h1234_5678);
        check("mthi_lo_untouched", lo, 32'd0);
        issue(MD_MTLO, 32'hCAFE_F00D, 32'd0);
        md_op = MD_MFLO; #1;
        check("mflo_e_hl", e_hl, 32'hCAFE_F00D);
        check("mtlo_hi_untouched", hi, 32'h1234_5678);
        md_op = MD_NONE; #1;
        check("none_e_hl", e_hl, 32'd0);

        // start with NONE: no effect
        issue(MD_NONE, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("none_busy", {31'd0, busy}, 32'd0);
        check("none_hi", hi, 32'h1234_5678);
        check("none_lo", lo, 32'hCAFE_F00D);

        // Multi-cycle arithmetic
        push("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
        issue(MD_MULT, 32'hFFFF_FFFE, 32'd3);
        drain("mult_neg");
        push("multu_max", 32'h0000_0001, 32'hFFFF_FFFE, 5);
        issue(MD_MULTU, 32'hFFFF_FFFF, 32'd2);
        drain("multu_max");
        push("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
        issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);
        drain("div_neg");
        push("divu_zero", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
        issue(MD_DIVU, 32'd7, 32'd0);
        drain("divu_zero");
        push("div_ovf", 32'h0000_0000, 32'h8000_0000, 10);
        issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        drain("div_ovf");
        push("div_neg_divisor", 32'h0000_0001, 32'hFFFF_FFFD, 10);
        issue(MD_DIV, 32'd7, 32'hFFFF_FFFE);
        drain("div_neg_divisor");
        push("divu_basic", 32'd2, 32'd14, 10);
        issue(MD_DIVU, 32'd100, 32'd7);
        drain("divu_basic");

        // Back-to-back: operand change and ignored start during busy, then restart right after
        push("b2b_first", 32'd0, 32'd42, 5);
        issue(MD_MULT, 32'd6, 32'd7);
        src_a = 32'd99;
        @(negedge clk);
        check("start_while_busy_busy", {31'd0, busy}, 32'd1);
        if (busy) begin
            ignored_starts++;
            $display("[TB] note: start issued while busy (hazard unit would have stalled)");
        end
        start = 1'b1; md_op = MD_DIV; src_a = 32'd100; src_b = 32'd3;
        @(negedge clk);
        start = 1'b0; md_op = MD_NONE;
        guard = 0;
        while (busy && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("b2b_busy_fell", {31'd0, busy}, 32'd0);
        push("b2b_second", 32'd1, 32'd0, 5);
        start = 1'b1; md_op = MD_MULT; src_a = 32'h0001_0000; src_b = 32'h0001_0000;
        @(negedge clk);
        start = 1'b0; md_op = MD_NONE;
        check("b2b_accepted", {31'd0, busy}, 32'd1);
        drain("b2b");
        check("ignored_start_count", 32'(ignored_starts), 32'd1);

        // Reset mid-DIV with the counter at 4
        issue(MD_DIV, 32'd100, 32'd7);
        repeat (6) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_hi", hi, 32'd0);
        check("rst_mid_lo", lo, 32'd0);
        @(posedge clk); #2 rst = 1'b0;
        repeat (15) @(negedge clk);
        check("rst_after_busy", {31'd0, busy}, 32'd0);
        check("rst_after_hi", hi, 32'd0);
        check("rst_after_lo", lo, 32'd0);
        check("rst_sb_empty", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
